board_sequencer: RTL and testbench

//  Parametrised current-generation board register with generation control for the Game of Life core.

---
 rtl/board_pkg.sv | 17 +
 rtl/gen_tick_divider.sv | 30 +++
 rtl/board_sequencer.sv | 142 ++++++++++++++
 tb/tb_board_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared defaults and sequencer state encoding for the Game of Life board sequencer.
package board_pkg;

    localparam int ROWS_DEF     = 16;
    localparam int COLS_DEF     = 16;
    localparam int BOARD_W_DEF  = ROWS_DEF * COLS_DEF;
    localparam int GEN_W_DEF    = 16;
    localparam int TICK_DIV_DEF = 25_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REQ  = 2'd2,
        HALT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/gen_tick_divider.sv
// Generation pacing counter: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count; clear forces it back to zero.
module gen_tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tc_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tc_o ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/board_sequencer.sv
// Current-generation board register and generation control for the Game of Life core.
// Optional period-2 oscillator detection is enabled by defining BOARD_SEQ_OSC_DETECT_EN.
module board_sequencer
    import board_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int GEN_W    = GEN_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    localparam int BOARD_W = ROWS * COLS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               run_i,
    input  logic               pause_i,
    input  logic               step_i,
    input  logic [BOARD_W-1:0] setup_board,
    output logic               alg_req,
    input  logic               alg_valid,
    input  logic [BOARD_W-1:0] alg_board,
    output logic [BOARD_W-1:0] board_o,
    output logic [GEN_W-1:0]   gen_count,
    output logic [1:0]         state_o,
    output logic               stable_o,
    output logic               osc_o
);

    seq_state_e         state_q;
    seq_state_e         ret_q;
    logic [BOARD_W-1:0] board_q;
    logic [GEN_W-1:0]   gen_q;
    logic               stable_q;
    logic               tick_tc;
    logic               do_load;
    logic               osc_hit;

    // The counter only runs in RUN, so every entry to RUN starts a fresh interval.
    gen_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != RUN),
        .en_i    (state_q == RUN),
        .tc_o    (tick_tc)
    );

    // A pending engine transaction is never abandoned, so load waits outside REQ.
    assign do_load = load_i && (state_q != REQ);

`ifdef BOARD_SEQ_OSC_DETECT_EN
    logic [BOARD_W-1:0] prev_q;
    logic               osc_q;

    assign osc_hit = (alg_board == prev_q) && (alg_board != board_q);
    assign osc_o   = osc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            osc_q  <= 1'b0;
        end else if (do_load) begin
            prev_q <= '0;
            osc_q  <= 1'b0;
        end else if (state_q == REQ && alg_valid) begin
            prev_q <= board_q;
            if (alg_board != board_q && osc_hit) begin
                osc_q <= 1'b1;
            end
        end
    end
`else
    assign osc_hit = 1'b0;
    assign osc_o   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ret_q    <= IDLE;
            board_q  <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else if (do_load) begin
            state_q  <= IDLE;
            board_q  <= setup_board;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pause_i) begin
                        state_q <= IDLE;
                    end else if (step_i) begin
                        state_q <= REQ;
                        ret_q   <= IDLE;
                    end else if (run_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (pause_i) begin
                        state_q <= IDLE;
                    end else if (tick_tc) begin
                        state_q <= REQ;
                        ret_q   <= RUN;
                    end
                end
                REQ: begin
                    if (alg_valid) begin
                        board_q <= alg_board;
                        gen_q   <= gen_q + GEN_W'(1);
                        if (alg_board == board_q) begin
                            stable_q <= 1'b1;
                            state_q  <= HALT;
                        end else if (osc_hit) begin
                            state_q <= HALT;
                        end else begin
                            state_q <= pause_i ? IDLE : ret_q;
                        end
                    end else if (pause_i) begin
                        ret_q <= IDLE;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alg_req   = (state_q == REQ);
    assign board_o   = board_q;
    assign gen_count = gen_q;
    assign state_o   = state_q;
    assign stable_o  = stable_q;

endmodule

// File: tb/tb_board_sequencer.sv
// Self-checking bench for board_sequencer: the bench plays the algorithm engine
// with a real Game of Life rule and predicts the sequencer from its command rules.
module tb_board_sequencer;

    localparam int ROWS     = 16;
    localparam int COLS     = 16;
    localparam int BW       = ROWS * COLS;
    localparam int GEN_W    = 4;
    localparam int TICK_DIV = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

`ifdef BOARD_SEQ_OSC_DETECT_EN
    localparam bit OSC_EN = 1'b1;
`else
    localparam bit OSC_EN = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            load_i;
    logic            run_i;
    logic            pause_i;
    logic            step_i;
    logic [BW-1:0]   setup_board;
    logic            alg_req;
    logic            alg_valid;
    logic [BW-1:0]   alg_board;
    logic [BW-1:0]   board_o;
    logic [GEN_W-1:0] gen_count;
    logic [1:0]      state_o;
    logic            stable_o;
    logic            osc_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of what the sequencer should be showing.
    logic [BW-1:0]    m_board;
    logic [BW-1:0]    m_prev;
    logic [GEN_W-1:0] m_gen;
    logic [1:0]       m_state;
    logic [1:0]       m_ret;
    logic             m_stable;
    logic             m_osc;

    board_sequencer #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .GEN_W    (GEN_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_i),
        .run_i       (run_i),
        .pause_i     (pause_i),
        .step_i      (step_i),
        .setup_board (setup_board),
        .alg_req     (alg_req),
        .alg_valid   (alg_valid),
        .alg_board   (alg_board),
        .board_o     (board_o),
        .gen_count   (gen_count),
        .state_o     (state_o),
        .stable_o    (stable_o),
        .osc_o       (osc_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int r, input int c);
        logic [BW-1:0] n;
        n = b;
        n[r*COLS + c] = 1'b1;
        return n;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Conway's rule on a bounded grid (cells beyond the edge are dead).
    function automatic logic [BW-1:0] life(input logic [BW-1:0] b);
        logic [BW-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                            c + dc >= 0 && c + dc < COLS)
                            cnt += int'(b[(r+dr)*COLS + c + dc]);
                    end
                end
                n[r*COLS + c] = (cnt == 3) || (cnt == 2 && b[r*COLS + c]);
            end
        end
        return n;
    endfunction

    task automatic model_reset();
        m_board = '0; m_prev = '0; m_gen = '0;
        m_state = S_IDLE; m_ret = S_IDLE; m_stable = 1'b0; m_osc = 1'b0;
    endtask

    task automatic model_load(input logic [BW-1:0] b);
        m_board = b; m_prev = '0; m_gen = '0;
        m_state = S_IDLE; m_stable = 1'b0; m_osc = 1'b0;
    endtask

    // One completed engine transaction delivering generation nb.
    task automatic model_complete(input logic [BW-1:0] nb);
        if (nb == m_board) begin
            m_stable = 1'b1;
            m_state  = S_HALT;
        end else if (OSC_EN && nb == m_prev) begin
            m_osc   = 1'b1;
            m_state = S_HALT;
        end else begin
            m_state = m_ret;
        end
        m_prev  = m_board;
        m_board = nb;
        m_gen   = m_gen + GEN_W'(1);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " board"},  board_o,             m_board);
        check({tag, " gen"},    BW'(gen_count),      BW'(m_gen));
        check({tag, " state"},  BW'(state_o),        BW'(m_state));
        check({tag, " req"},    BW'(alg_req),        BW'(m_state == S_REQ));
        check({tag, " stable"}, BW'(stable_o),       BW'(m_stable));
        check({tag, " osc"},    BW'(osc_o),          BW'(m_osc));
    endtask

    // ---------------- drivers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [BW-1:0] b);
        setup_board = b; load_i = 1'b1;
        cyc();
        load_i = 1'b0;
        model_load(b);
    endtask

    task automatic do_step();
        step_i = 1'b1;
        cyc();
        step_i = 1'b0;
        m_state = S_REQ; m_ret = S_IDLE;
    endtask

    task automatic do_run();
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        m_state = S_RUN;
    endtask

    // Waits (bounded) for alg_req while running and checks the pacing gap.
    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (alg_req !== 1'b1 && k < 50) begin
            cyc();
            k++;
        end
        check({tag, " gap"}, BW'(k), BW'(TICK_DIV));
        m_state = S_REQ; m_ret = S_RUN;
    endtask

    // Engine answer after lat cycles; pause_i pulsed on cycle pause_at (-1: none).
    task automatic serve(input string tag, input logic [BW-1:0] nb, input int lat, input int pause_at);
        for (int i = 0; i < lat; i++) begin
            if (i == pause_at) pause_i = 1'b1;
            cyc();
            pause_i = 1'b0;
            if (i == pause_at) m_ret = S_IDLE;
        end
        check_all({tag, " wait"});
        alg_valid = 1'b1; alg_board = nb;
        cyc();
        alg_valid = 1'b0; alg_board = rand_board();
        model_complete(nb);
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [BW-1:0] glider, block, blinker, b;

    initial begin
        glider  = put(put(put(put(put('0, 1, 2), 2, 3), 3, 1), 3, 2), 3, 3);
        block   = put(put(put(put('0, 5, 5), 5, 6), 6, 5), 6, 6);
        blinker = put(put(put('0, 7, 6), 7, 7), 7, 8);

        reset = 1'b1; load_i = 1'b0; run_i = 1'b0; pause_i = 1'b0; step_i = 1'b0;
        setup_board = '0; alg_valid = 1'b0; alg_board = '0;
        model_reset();
        repeat (2) cyc();
        check_all("reset");
        reset = 1'b0;
        cyc();
        check_all("post_reset");

        // Load glider, single step with engine latency 3.
        do_load(glider);
        check_all("load_glider");
        do_step();
        check_all("step_req");
        serve("step_glider", life(glider), 3, -1);

        // Random boards, single steps with random engine latency.
        for (int t = 0; t < 5; t++) begin
            b = rand_board();
            do_load(b);
            check_all("load_rand");
            do_step();
            serve("step_rand", life(b), int'($urandom_range(0, 4)), -1);
        end

        // Free running, pause lands mid-transaction on the third request.
        do_load(rand_board());
        do_run();
        check_all("run_start");
        for (int r = 0; r < 3; r++) begin
            if (m_state == S_RUN) begin
                wait_req("run");
                serve("run_gen", life(m_board), int'($urandom_range(1, 4)), (r == 2) ? 0 : -1);
            end
        end
        repeat (3) begin
            cyc();
            check_all("paused_idle");
        end

        // Still life halts; only load leaves HALT.
        do_load(block);
        do_step();
        serve("block", life(block), 2, -1);
        do_run();
        m_state = S_HALT;
        check_all("halt_run_ignored");
        do_step();
        m_state = S_HALT;
        check_all("halt_step_ignored");
        alg_valid = 1'b1; alg_board = rand_board();
        cyc();
        alg_valid = 1'b0;
        check_all("halt_valid_ignored");
        do_load(glider);
        check_all("halt_load_exit");

        // Blinker run: halts after gen 2 with oscillator detection, else keeps running.
        do_load(blinker);
        do_run();
        for (int g = 0; g < 4; g++) begin
            if (m_state == S_RUN) begin
                wait_req("blinker");
                serve("blinker_gen", life(m_board), int'($urandom_range(0, 3)), -1);
            end
        end
        check_all("blinker_end");
        if (m_state == S_RUN) begin
            pause_i = 1'b1;
            cyc();
            pause_i = 1'b0;
            m_state = S_IDLE;
            check_all("blinker_pause");
        end

        // Generation counter wraps through 2^GEN_W.
        do_load(rand_board());
        for (int g = 0; g < (1 << GEN_W) + 1; g++) begin
            do_step();
            serve("wrap", rand_board(), int'($urandom_range(0, 2)), -1);
        end

        // Reset asserted in the middle of a transaction.
        do_load(glider);
        do_step();
        cyc();
        #2 reset = 1'b1;
        model_reset();
        cyc();
        check_all("reset_mid_req");
        reset = 1'b0;
        cyc();
        check_all("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
